multicycle_control: RTL and testbench



---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Memory handshake bundle between the multi-cycle control unit and the
// instruction/data memories.
//   instr_req             : control -> imem, fetch request (held until ack)
//   instr_ack             : imem -> control, fetch complete
//   data_req              : control -> dmem, data access request
//   data_ack              : dmem -> control, data access complete
//   data_mem_write_enable : control -> dmem, access is a store
// Modports: master = control unit, slave = memory side.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
  logic instr_req;
  logic instr_ack;
  logic data_req;
  logic data_ack;
  logic data_mem_write_enable;

  modport master (
    output instr_req,
    output data_req,
    output data_mem_write_enable,
    input  instr_ack,
    input  data_ack
  );

  modport slave (
    input  instr_req,
    input  data_req,
    input  data_mem_write_enable,
    output instr_ack,
    output data_ack
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle control unit for an RV32I core. Walks each instruction through
// FETCH/DECODE/EXEC/(MEM|BTGT)/WB, drives the datapath selects, and handshakes
// with instruction and data memory. Illegal opcodes and ack timeouts park the
// unit in FAULT until reset.
// Parameters:
//   ALU_CTRL_W   : width of alu_control (>= 4, encodings zero-extended)
//   MEM_WAIT_MAX : wait cycles without ack before a bus fault (1..255)
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   bus                   : memory handshake (master side)
//   instr                 : IR contents, valid from DECODE onward
//   alu_zero/lt/ltu       : ALU flags for branch resolution
//   ir_write, pc_write, pc_src, reg_write_enable : datapath enables
//   alu_src_a/b, result_src, imm_src, alu_control : datapath selects
//   illegal_instr, bus_fault : sticky fault flags; halted : in FAULT
// Optional build macro CTRL_INSTRET_EN adds instret[31:0], a retired
// instruction counter.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int ALU_CTRL_W   = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_control_if.master    bus,
  input  logic [31:0]             instr,
  input  logic                    alu_zero,
  input  logic                    alu_lt,
  input  logic                    alu_ltu,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    reg_write_enable,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              result_src,
  output logic [2:0]              imm_src,
  output logic [ALU_CTRL_W-1:0]   alu_control,
  output logic                    illegal_instr,
  output logic                    bus_fault,
  output logic                    halted
`ifdef CTRL_INSTRET_EN
  , output logic [31:0]           instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BTGT, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } class_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                         ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                         ALU_SRA = 4'd9;
  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  typedef struct packed {
    logic       instr_req;
    logic       data_req;
    logic       data_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write_enable;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_op;
  } ctl_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_reg, wait_next, wait_inc;
  logic        taken_reg, taken_next;
  logic        illegal_reg, illegal_next;
  logic        bus_fault_reg, bus_fault_next;
  logic [31:0] instret_reg, instret_next;
  class_t      cls;
  logic [3:0]  alu_op;
  logic        taken;
  ctl_t        ctl;

  wire [6:0] opcode = instr[6:0];
  wire [2:0] funct3 = instr[14:12];
  wire [6:0] funct7 = instr[31:25];

  // Register fields and most immediate bits are consumed by the datapath.
  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // Instruction class, with illegal funct3/funct7 combinations mapped to C_BAD.
  always_comb begin
    cls = C_BAD;
    case (opcode)
      7'b0110011: if (funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    cls = C_R;
      7'b0010011: begin
        if (funct3 == 3'b001)      cls = (funct7 == 7'h00) ? C_IALU : C_BAD;
        else if (funct3 == 3'b101) cls = (funct7 == 7'h00 || funct7 == 7'h20) ? C_IALU : C_BAD;
        else                       cls = C_IALU;
      end
      7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) cls = C_LOAD;
      7'b0100011: if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) cls = C_STORE;
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) cls = C_BRANCH;
      7'b1101111: cls = C_JAL;
      7'b1100111: if (funct3 == 3'b000) cls = C_JALR;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      default:    cls = C_BAD;
    endcase
  end

  // ALU op for R and I-ALU. Only R-type may select SUB; funct7[5] on an
  // I-type add is just an immediate bit.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (cls == C_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  assign wait_inc = wait_reg + 8'd1;

  always_comb begin
    ctl            = '0;
    state_next     = state_reg;
    taken_next     = taken_reg;
    illegal_next   = illegal_reg;
    bus_fault_next = bus_fault_reg;
    wait_next      = wait_reg;
    case (state_reg)
      S_FETCH: begin
        ctl.instr_req = 1'b1;
        if (bus.instr_ack) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_next   = S_DECODE;
        end else begin
          wait_next = wait_inc;
          if (wait_inc == WAIT_MAX) begin
            bus_fault_next = 1'b1;
            state_next     = S_FAULT;
          end
        end
      end
      S_DECODE: begin
        if (cls == C_BAD) begin
          illegal_next = 1'b1;
          state_next   = S_FAULT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_WB;
        case (cls)
          C_R:     ctl.alu_op = alu_op;
          C_IALU:  begin ctl.alu_src_b = 2'd1; ctl.alu_op = alu_op; end
          C_LOAD:  begin ctl.alu_src_b = 2'd1; state_next = S_MEM; end
          C_STORE: begin ctl.alu_src_b = 2'd1; ctl.imm_src = 3'd1; state_next = S_MEM; end
          C_BRANCH: begin
            ctl.alu_op  = ALU_SUB;
            ctl.imm_src = 3'd2;
            taken_next  = taken;
            state_next  = S_BTGT;
          end
          C_JAL: begin
            ctl.alu_src_a = 2'd1; ctl.alu_src_b = 2'd1; ctl.imm_src = 3'd4;
            ctl.pc_write  = 1'b1; ctl.pc_src = 1'b1;
          end
          C_JALR: begin
            ctl.alu_src_b = 2'd1;
            ctl.pc_write  = 1'b1; ctl.pc_src = 1'b1;
          end
          C_LUI:   begin ctl.alu_src_a = 2'd2; ctl.alu_src_b = 2'd1; ctl.imm_src = 3'd3; end
          C_AUIPC: begin ctl.alu_src_a = 2'd1; ctl.alu_src_b = 2'd1; ctl.imm_src = 3'd3; end
          default: begin illegal_next = 1'b1; state_next = S_FAULT; end
        endcase
      end
      S_BTGT: begin
        ctl.alu_src_a = 2'd1;
        ctl.alu_src_b = 2'd1;
        ctl.imm_src   = 3'd2;
        ctl.pc_write  = taken_reg;
        ctl.pc_src    = taken_reg;
        state_next    = S_FETCH;
      end
      S_MEM: begin
        ctl.data_req = 1'b1;
        ctl.data_we  = (cls == C_STORE);
        if (bus.data_ack) begin
          state_next = (cls == C_STORE) ? S_FETCH : S_WB;
        end else begin
          wait_next = wait_inc;
          if (wait_inc == WAIT_MAX) begin
            bus_fault_next = 1'b1;
            state_next     = S_FAULT;
          end
        end
      end
      S_WB: begin
        ctl.reg_write_enable = 1'b1;
        if (cls == C_LOAD)                     ctl.result_src = 2'd1;
        else if (cls == C_JAL || cls == C_JALR) ctl.result_src = 2'd2;
        state_next = S_FETCH;
      end
      default: state_next = S_FAULT;
    endcase
    if (state_next != state_reg) wait_next = '0;
  end

  // An instruction retires when the unit returns to FETCH from a working state.
  always_comb begin
    instret_next = instret_reg;
    if (state_next == S_FETCH &&
        (state_reg == S_WB || state_reg == S_BTGT || state_reg == S_MEM))
      instret_next = instret_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      wait_reg      <= '0;
      taken_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      bus_fault_reg <= 1'b0;
      instret_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      wait_reg      <= wait_next;
      taken_reg     <= taken_next;
      illegal_reg   <= illegal_next;
      bus_fault_reg <= bus_fault_next;
      instret_reg   <= instret_next;
    end
  end

  // Everything is forced low while reset is held, independent of state.
  assign bus.instr_req             = rst_n & ctl.instr_req;
  assign bus.data_req              = rst_n & ctl.data_req;
  assign bus.data_mem_write_enable = rst_n & ctl.data_we;
  assign ir_write         = rst_n & ctl.ir_write;
  assign pc_write         = rst_n & ctl.pc_write;
  assign pc_src           = rst_n & ctl.pc_src;
  assign reg_write_enable = rst_n & ctl.reg_write_enable;
  assign alu_src_a        = rst_n ? ctl.alu_src_a  : 2'd0;
  assign alu_src_b        = rst_n ? ctl.alu_src_b  : 2'd0;
  assign result_src       = rst_n ? ctl.result_src : 2'd0;
  assign imm_src          = rst_n ? ctl.imm_src    : 3'd0;
  assign alu_control      = rst_n ? ALU_CTRL_W'(ctl.alu_op) : '0;
  assign illegal_instr    = rst_n & illegal_reg;
  assign bus_fault        = rst_n & bus_fault_reg;
  assign halted           = rst_n & (state_reg == S_FAULT);

`ifdef CTRL_INSTRET_EN
  assign instret = rst_n ? instret_reg : 32'd0;
`else
  logic unused_instret;
  assign unused_instret = ^instret_next;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Each instruction run pushes the
// expected per-cycle outputs (cycle index, field, value) to a scoreboard
// queue; the run loop drives acks at the falling edge and pops/compares the
// entries due in that cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int F_IREQ = 0, F_DREQ = 1, F_WE = 2, F_IRW = 3, F_PCW = 4,
                 F_PCSRC = 5, F_RWE = 6, F_SRCA = 7, F_SRCB = 8, F_RES = 9,
                 F_IMM = 10, F_ALU = 11, F_ILL = 12, F_BUS = 13, F_HALT = 14;

  typedef struct {
    int          cyc;
    int          field;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic        ir_write, pc_write, pc_src, reg_write_enable;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic        illegal_instr, bus_fault, halted;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  int   n_assert = 0;
  int   n_fail = 0;
  int   exp_instret = 0;
  exp_t sb[$];

  multicycle_control_if bus_if ();

  multicycle_control #(.ALU_CTRL_W(4), .MEM_WAIT_MAX(15)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus_if.master),
    .instr            (instr),
    .alu_zero         (alu_zero),
    .alu_lt           (alu_lt),
    .alu_ltu          (alu_ltu),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .reg_write_enable (reg_write_enable),
    .alu_src_a        (alu_src_a),
    .alu_src_b        (alu_src_b),
    .result_src       (result_src),
    .imm_src          (imm_src),
    .alu_control      (alu_control),
    .illegal_instr    (illegal_instr),
    .bus_fault        (bus_fault),
    .halted           (halted)
`ifdef CTRL_INSTRET_EN
    , .instret        (instret)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic string fname(input int f);
    case (f)
      F_IREQ:  return "instr_req";
      F_DREQ:  return "data_req";
      F_WE:    return "data_mem_write_enable";
      F_IRW:   return "ir_write";
      F_PCW:   return "pc_write";
      F_PCSRC: return "pc_src";
      F_RWE:   return "reg_write_enable";
      F_SRCA:  return "alu_src_a";
      F_SRCB:  return "alu_src_b";
      F_RES:   return "result_src";
      F_IMM:   return "imm_src";
      F_ALU:   return "alu_control";
      F_ILL:   return "illegal_instr";
      F_BUS:   return "bus_fault";
      default: return "halted";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int f);
    case (f)
      F_IREQ:  return 32'(bus_if.instr_req);
      F_DREQ:  return 32'(bus_if.data_req);
      F_WE:    return 32'(bus_if.data_mem_write_enable);
      F_IRW:   return 32'(ir_write);
      F_PCW:   return 32'(pc_write);
      F_PCSRC: return 32'(pc_src);
      F_RWE:   return 32'(reg_write_enable);
      F_SRCA:  return 32'(alu_src_a);
      F_SRCB:  return 32'(alu_src_b);
      F_RES:   return 32'(result_src);
      F_IMM:   return 32'(imm_src);
      F_ALU:   return 32'(alu_control);
      F_ILL:   return 32'(illegal_instr);
      F_BUS:   return 32'(bus_fault);
      default: return 32'(halted);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic want(input int c, input int f, input logic [31:0] v);
    exp_t e;
    e.cyc = c; e.field = f; e.val = v;
    sb.push_back(e);
  endtask

  // Runs cycles 0..n from a FETCH cycle. Acks / reset are asserted only in
  // the cycle index given (-1 = never).
  task automatic run(input string name, input logic [31:0] ins, input int n,
                     input int iack_c, input int dack_c, input int rst_c,
                     input logic z, input logic lt, input logic ltu,
                     input bit completes);
    exp_t e;
    instr = ins; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      bus_if.instr_ack = (c == iack_c);
      bus_if.data_ack  = (c == dack_c);
      rst_n            = (c != rst_c);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        check($sformatf("%s c%0d %s", name, c, fname(e.field)), sample(e.field), e.val);
      end
    end
    bus_if.instr_ack = 1'b0;
    bus_if.data_ack  = 1'b0;
    rst_n            = 1'b1;
    if (rst_c >= 0) exp_instret = 0;
    else if (completes) exp_instret++;
`ifdef CTRL_INSTRET_EN
    check({name, " instret"}, instret, 32'(exp_instret));
`endif
    sb.delete();
  endtask

  // Applies one reset edge and releases just after it, so the next falling
  // edge is the first FETCH cycle with a cleared wait counter.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_instret = 0;
  endtask

  initial begin
    bus_if.instr_ack = 1'b0;
    bus_if.data_ack  = 1'b0;

    // Held in reset: all outputs low.
    repeat (2) @(negedge clk);
    #1;
    check("reset instr_req", 32'(bus_if.instr_req), 32'd0);
    check("reset data_req", 32'(bus_if.data_req), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset illegal_instr", 32'(illegal_instr), 32'd0);
    check("reset bus_fault", 32'(bus_fault), 32'd0);
    check("reset reg_write_enable", 32'(reg_write_enable), 32'd0);
    do_reset();

    // ADD x3,x1,x2
    want(0, F_IREQ, 1); want(0, F_IRW, 1); want(0, F_PCW, 1); want(0, F_PCSRC, 0);
    want(1, F_IREQ, 0); want(1, F_RWE, 0);
    want(2, F_ALU, 0); want(2, F_SRCA, 0); want(2, F_SRCB, 0); want(2, F_RWE, 0);
    want(3, F_RWE, 1); want(3, F_RES, 0);
    want(4, F_IREQ, 1); want(4, F_RWE, 0);
    run("add", 32'h002081B3, 4, 0, -1, -1, 0, 0, 0, 1);

    want(2, F_ALU, 1); want(3, F_RWE, 1); want(4, F_IREQ, 1);
    run("sub", 32'h402081B3, 4, 0, -1, -1, 0, 0, 0, 1);

    want(2, F_ALU, 9); want(2, F_SRCB, 1); want(2, F_IMM, 0); want(3, F_RWE, 1); want(4, F_IREQ, 1);
    run("srai", 32'h4020D193, 4, 0, -1, -1, 0, 0, 0, 1);

    // ADDI with imm bit 30 set must stay ADD.
    want(2, F_ALU, 0); want(2, F_SRCB, 1); want(4, F_IREQ, 1);
    run("addi", 32'h40008093, 4, 0, -1, -1, 0, 0, 0, 1);

    want(2, F_ALU, 6); want(4, F_IREQ, 1);
    run("sltu", 32'h0020B1B3, 4, 0, -1, -1, 0, 0, 0, 1);

    // LW with data_ack on the fourth MEM cycle.
    want(2, F_ALU, 0); want(2, F_SRCB, 1); want(2, F_IMM, 0); want(2, F_DREQ, 0);
    want(3, F_DREQ, 1); want(3, F_WE, 0);
    want(4, F_DREQ, 1); want(5, F_DREQ, 1); want(6, F_DREQ, 1); want(6, F_RWE, 0);
    want(7, F_DREQ, 0); want(7, F_RWE, 1); want(7, F_RES, 1);
    want(8, F_IREQ, 1);
    run("lw", 32'h0000A183, 8, 0, 6, -1, 0, 0, 0, 1);

    want(2, F_IMM, 1); want(2, F_SRCB, 1); want(2, F_ALU, 0);
    want(3, F_DREQ, 1); want(3, F_WE, 1); want(3, F_RWE, 0);
    want(4, F_IREQ, 1); want(4, F_DREQ, 0);
    run("sw", 32'h0020A223, 4, 0, 3, -1, 0, 0, 0, 1);

    want(2, F_ALU, 1); want(2, F_SRCB, 0);
    want(3, F_PCW, 1); want(3, F_PCSRC, 1); want(3, F_SRCA, 1); want(3, F_SRCB, 1);
    want(3, F_IMM, 2); want(3, F_ALU, 0); want(3, F_RWE, 0);
    want(4, F_IREQ, 1);
    run("beq_taken", 32'h00208463, 4, 0, -1, -1, 1, 0, 0, 1);

    want(3, F_PCW, 0); want(3, F_PCSRC, 0); want(4, F_IREQ, 1);
    run("beq_not", 32'h00208463, 4, 0, -1, -1, 0, 1, 1, 1);

    want(3, F_PCW, 1); want(4, F_IREQ, 1);
    run("bltu_taken", 32'h0020E463, 4, 0, -1, -1, 0, 0, 1, 1);

    want(3, F_PCW, 0); want(4, F_IREQ, 1);
    run("bge_not", 32'h0020D463, 4, 0, -1, -1, 0, 1, 0, 1);

    want(2, F_PCW, 1); want(2, F_PCSRC, 1); want(2, F_SRCA, 1); want(2, F_SRCB, 1); want(2, F_IMM, 4);
    want(3, F_RWE, 1); want(3, F_RES, 2); want(3, F_PCW, 0);
    want(4, F_IREQ, 1);
    run("jal", 32'h008000EF, 4, 0, -1, -1, 0, 0, 0, 1);

    want(2, F_PCW, 1); want(2, F_SRCA, 0); want(2, F_SRCB, 1); want(2, F_IMM, 0);
    want(3, F_RES, 2); want(4, F_IREQ, 1);
    run("jalr", 32'h000080E7, 4, 0, -1, -1, 0, 0, 0, 1);

    want(2, F_SRCA, 2); want(2, F_SRCB, 1); want(2, F_IMM, 3); want(3, F_RWE, 1); want(4, F_IREQ, 1);
    run("lui", 32'h123452B7, 4, 0, -1, -1, 0, 0, 0, 1);

    want(2, F_SRCA, 1); want(2, F_IMM, 3); want(3, F_RES, 0); want(4, F_IREQ, 1);
    run("auipc", 32'h00001297, 4, 0, -1, -1, 0, 0, 0, 1);

    // Reset while a store waits in MEM.
    want(3, F_DREQ, 1); want(3, F_WE, 1);
    want(4, F_DREQ, 0); want(4, F_IREQ, 0);
    want(5, F_DREQ, 0); want(5, F_WE, 0); want(5, F_IREQ, 1); want(5, F_ILL, 0); want(5, F_BUS, 0);
    run("sw_reset", 32'h0020A223, 5, 0, -1, 4, 0, 0, 0, 0);

    // Instruction memory never acks.
    do_reset();
    want(0, F_IREQ, 1);
    want(14, F_IREQ, 1); want(14, F_BUS, 0); want(14, F_HALT, 0);
    want(15, F_IREQ, 0); want(15, F_BUS, 1); want(15, F_HALT, 1);
    run("timeout", 32'h002081B3, 15, -1, -1, -1, 0, 0, 0, 0);

    do_reset();
    @(negedge clk); #1;
    check("post_fault_reset bus_fault", 32'(bus_fault), 32'd0);
    check("post_fault_reset halted", 32'(halted), 32'd0);
    do_reset();

    // Unknown opcode.
    want(1, F_ILL, 0); want(1, F_HALT, 0);
    want(2, F_ILL, 1); want(2, F_HALT, 1); want(2, F_IREQ, 0);
    want(4, F_IREQ, 0); want(4, F_HALT, 1);
    run("op7f", 32'h0000007F, 4, 0, -1, -1, 0, 0, 0, 0);

    do_reset();
    want(2, F_ILL, 1); want(2, F_HALT, 1);
    run("r_funct7", 32'h802081B3, 2, 0, -1, -1, 0, 0, 0, 0);

    do_reset();
    want(2, F_ILL, 1); want(2, F_HALT, 1);
    run("slli_f7", 32'h40209193, 2, 0, -1, -1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
